// File: rtl/softmax_row_packer_pkg.sv
// Shared constants, FSM state type and lane helpers for the softmax row packer
// and the blocks that consume its packed 256-bit words.
package softmax_row_packer_pkg;

  localparam int LANES  = 32;
  localparam int DW     = 8;
  localparam int WORD_W = LANES * DW;
  localparam int LEN_W  = 6;

  localparam logic [DW-1:0] PAD = 8'h80;

  typedef enum logic {
    ST_FILL,
    ST_WAIT
  } state_t;

  function automatic logic [DW-1:0] lane_of(input logic [WORD_W-1:0] word,
                                            input logic [4:0] idx);
    return word[{idx, 3'b000} +: DW];
  endfunction

  // Out-of-range lengths (0 or above LANES) mean a full row.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(LANES)) begin
      return LEN_W'(LANES);
    end
    return len;
  endfunction

endpackage

// File: rtl/softmax_row_packer_row_out.sv
// Output holding register: keeps a packed row stable until the consumer takes it
// and counts every row handed into it.
module softmax_row_packer_row_out
  import softmax_row_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              out_ready,
  output logic              slot_free,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic [15:0]       row_count
);

  assign slot_free = !out_valid || out_ready;

  // A new row may replace the current one in the same cycle it is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      row_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_len   <= load_len;
      row_count <= row_count + 16'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_row_packer.sv
// Packs a row of up to 32 signed int8 scores into a 256-bit word for softmax;
// a fill buffer lets the next row start while the previous word waits.
module softmax_row_packer
  import softmax_row_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_score,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic [15:0]       row_count
);

  state_t                   state_q, state_d;
  logic [LANES-1:0][DW-1:0] fill_buf, with_byte;
  logic [LEN_W-1:0]         cnt_q, cnt_inc, len_q, eff_len, load_len;
  logic [WORD_W-1:0]        load_data;
  logic                     xfer, close, handoff, load, slot_free;

  // Datapath decode: current byte, row-close detection and what to hand off.
  always_comb begin
    in_ready  = rst && (state_q == ST_FILL);
    xfer      = in_valid && in_ready;
    eff_len   = (cnt_q == '0) ? norm_len(seq_len) : len_q;
    cnt_inc   = cnt_q + LEN_W'(1);
    close     = xfer && ((cnt_inc == eff_len) || in_last);
    with_byte = fill_buf;
    if (xfer) begin
      with_byte[cnt_q[4:0]] = in_score;
    end
    handoff   = (state_q == ST_WAIT) && out_valid && out_ready;
    load      = (close && slot_free) || handoff;
    load_data = (state_q == ST_WAIT) ? WORD_W'(fill_buf) : WORD_W'(with_byte);
    load_len  = (state_q == ST_WAIT) ? cnt_q : cnt_inc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (close && !slot_free) state_d = ST_WAIT;
      ST_WAIT: if (handoff) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // While parked in WAIT, cnt_q holds the closed row's length for out_len.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      len_q    <= '0;
      fill_buf <= {LANES{PAD}};
    end else begin
      state_q <= state_d;
      if (xfer && cnt_q == '0) begin
        len_q <= norm_len(seq_len);
      end
      if (load) begin
        fill_buf <= {LANES{PAD}};
        cnt_q    <= '0;
      end else if (xfer) begin
        fill_buf <= with_byte;
        cnt_q    <= cnt_inc;
      end
    end
  end

  softmax_row_packer_row_out u_row_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_len  (load_len),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_len   (out_len),
    .row_count (row_count)
  );

endmodule
